// File: rtl/sa_wdata_channel_if.sv
// ---------------------------------------------------------------------------
// sa_wdata_channel_if
// Bundle of the W-channel signals around one slave-side W arbitration stage:
// dispatcher-side W beats and WREADY, the AW-arbiter grant push / stall, and
// the registered W channel towards the slave.
//   slave  modport : view of the arbitration stage itself
//   master modport : view of everything around it (dispatchers, AW arbiter,
//                    downstream slave)
// ---------------------------------------------------------------------------
interface sa_wdata_channel_if #(
    parameter int MST_AMT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MST_ID_W   = $clog2(MST_AMT),
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH*MST_AMT-1:0]  dsp_WDATA_i;
    logic [MST_AMT-1:0]             dsp_WLAST_i;
    logic [MST_AMT-1:0]             dsp_WVALID_i;
    logic [MST_AMT-1:0]             dsp_WDATA_sel_i;
    logic [MST_AMT-1:0]             dsp_WREADY_o;

    logic [MST_ID_W-1:0]            sa_AW_mst_id_i;
    logic                           sa_AW_push_i;
    logic                           sa_AW_stall_o;

    logic [DATA_WIDTH-1:0]          s_WDATA_o;
    logic                           s_WLAST_o;
    logic                           s_WVALID_o;
    logic                           s_WREADY_i;

    logic [$clog2(FIFO_DEPTH):0]    pending_o;

    modport slave (
        input  dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i, dsp_WDATA_sel_i,
        output dsp_WREADY_o,
        input  sa_AW_mst_id_i, sa_AW_push_i,
        output sa_AW_stall_o,
        output s_WDATA_o, s_WLAST_o, s_WVALID_o,
        input  s_WREADY_i,
        output pending_o
    );

    modport master (
        output dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i, dsp_WDATA_sel_i,
        input  dsp_WREADY_o,
        output sa_AW_mst_id_i, sa_AW_push_i,
        input  sa_AW_stall_o,
        input  s_WDATA_o, s_WLAST_o, s_WVALID_o,
        output s_WREADY_i,
        input  pending_o
    );
endinterface

// File: rtl/sa_wdata_channel.sv
// ---------------------------------------------------------------------------
// sa_wdata_channel
// Per-slave W-channel arbitration stage. W beats from MST_AMT dispatchers are
// forwarded to one slave strictly in the order in which their AW transactions
// were granted to this slave. The grant order is kept in a small FIFO pushed
// by the AW arbiter and popped by the WLAST beat of each burst. The slave side
// is driven from a registered 2-entry skid buffer.
// Ports:
//   ACLK_i     clock
//   ARESETn_i  asynchronous active-low reset
//   bus        sa_wdata_channel_if.slave:
//                dsp_*      W beats / select / WREADY per dispatcher
//                sa_AW_*    grant push, granted master id, FIFO-full stall
//                s_W*       registered W channel to the slave
//                pending_o  granted bursts not yet fully forwarded
// ---------------------------------------------------------------------------
module sa_wdata_channel #(
    parameter int MST_AMT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MST_ID_W   = $clog2(MST_AMT),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                ACLK_i,
    input  logic                ARESETn_i,
    sa_wdata_channel_if.slave   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ---------------- grant-order FIFO ----------------
    logic [MST_ID_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic                stall_q;

    logic                head_vld;
    logic [MST_ID_W-1:0] head_id;
    logic                fifo_full;
    logic                push_ok;
    logic                pop;

    // ---------------- beat selection ----------------
    logic                  sel_ok;
    logic                  sb_ready;
    logic [MST_AMT-1:0]    wready;
    logic                  head_wvalid;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  head_wlast;
    logic                  beat_acc;

    // ---------------- skid buffer ----------------
    logic                  out_vld_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  skid_vld_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic                  skid_last_q;

    assign head_vld  = (count != '0);
    assign head_id   = fifo_mem[rd_ptr];
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

    // A push at full is only legal when the same cycle retires the head.
    assign pop     = beat_acc & head_wlast;
    assign push_ok = bus.sa_AW_push_i & (~fifo_full | pop);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= bus.sa_AW_mst_id_i;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            // Registered from the next count so it always equals (count == DEPTH).
            stall_q <= (count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.sa_AW_stall_o = stall_q;
    assign bus.pending_o     = count;

    // ---------------- head-master beat acceptance ----------------
    assign sb_ready = ~skid_vld_q;
    assign sel_ok   = head_vld & bus.dsp_WDATA_sel_i[head_id];

    always_comb begin
        wready      = '0;
        head_wvalid = 1'b0;
        head_wdata  = '0;
        head_wlast  = 1'b0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (MST_ID_W'(m) == head_id) begin
                wready[m]   = sel_ok & sb_ready;
                head_wvalid = bus.dsp_WVALID_i[m];
                head_wdata  = bus.dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
                head_wlast  = bus.dsp_WLAST_i[m];
            end
        end
    end

    assign bus.dsp_WREADY_o = wready;
    assign beat_acc         = head_wvalid & sel_ok & sb_ready;

    // ---------------- 2-entry skid buffer ----------------
    // out_* drives the slave directly; skid_* catches one beat when the
    // output is stalled. Upstream ready depends only on skid occupancy, so
    // there is no combinational path from s_WREADY_i to dsp_WREADY_o.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            if (!out_vld_q || bus.s_WREADY_i) begin
                if (skid_vld_q) begin
                    out_vld_q  <= 1'b1;
                    out_data_q <= skid_data_q;
                    out_last_q <= skid_last_q;
                    skid_vld_q <= 1'b0;
                end else if (beat_acc) begin
                    out_vld_q  <= 1'b1;
                    out_data_q <= head_wdata;
                    out_last_q <= head_wlast;
                end else begin
                    out_vld_q  <= 1'b0;
                end
            end else if (beat_acc) begin
                skid_vld_q  <= 1'b1;
                skid_data_q <= head_wdata;
                skid_last_q <= head_wlast;
            end
        end
    end

    assign bus.s_WVALID_o = out_vld_q;
    assign bus.s_WDATA_o  = out_data_q;
    assign bus.s_WLAST_o  = out_last_q;

    // The AW arbiter must honour the stall; a push at full without a pop is lost.
    a_no_push_when_full: assert property (
        @(posedge ACLK_i) disable iff (!ARESETn_i)
        !(bus.sa_AW_push_i && fifo_full && !pop)
    );

endmodule

// File: tb/tb_sa_wdata_channel.sv
module tb_sa_wdata_channel;

    localparam int MST_AMT    = 2;
    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    sa_wdata_channel_if #(
        .MST_AMT(MST_AMT), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    sa_wdata_channel #(
        .MST_AMT(MST_AMT), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ACLK_i    (clk),
        .ARESETn_i (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       id;
        logic [1:0] wv;
        logic [1:0] sel;
        logic [1:0] wl;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] e_wready;
        logic       e_sv;
        logic [7:0] e_sd;
        logic       e_sl;
        logic [2:0] e_pend;
        logic       e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic push, logic id, logic [1:0] wv, logic [1:0] sel,
                                logic [1:0] wl, logic [7:0] d0, logic [7:0] d1, logic rdy,
                                logic [1:0] ewr, logic esv, logic [7:0] esd, logic esl,
                                logic [2:0] ep, logic est);
        vec_t v;
        v.push = push; v.id = id; v.wv = wv; v.sel = sel; v.wl = wl;
        v.d0 = d0; v.d1 = d1; v.rdy = rdy;
        v.e_wready = ewr; v.e_sv = esv; v.e_sd = esd; v.e_sl = esl;
        v.e_pend = ep; v.e_stall = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic id, input logic [1:0] wv,
                         input logic [1:0] sel, input logic [1:0] wl,
                         input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
        bus.sa_AW_push_i    = push;
        bus.sa_AW_mst_id_i  = id;
        bus.dsp_WVALID_i    = wv;
        bus.dsp_WDATA_sel_i = sel;
        bus.dsp_WLAST_i     = wl;
        bus.dsp_WDATA_i     = {24'h0, d1, 24'h0, d0};
        bus.s_WREADY_i      = rdy;
    endtask

    initial begin
        // push,id, wv,   sel,  wl,   d0,    d1,   rdy | wready,sv, sd,  sl,pend,stall
        // ordering: id1 granted first, then id0
        vecs.push_back(mk(1,1,2'b11,2'b11,2'b00,8'h10,8'h20,1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(1,0,2'b11,2'b11,2'b00,8'h10,8'h20,1, 2'b10,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b11,2'b11,2'b10,8'h10,8'h21,1, 2'b10,1,8'h20,0,2,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b00,8'h10,8'h00,1, 2'b01,1,8'h21,1,1,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b01,8'h11,8'h00,1, 2'b01,1,8'h10,0,1,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,1,8'h11,1,0,0));
        // single master 4-beat burst
        vecs.push_back(mk(1,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b00,8'hA0,8'h00,1, 2'b01,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b00,8'hA1,8'h00,1, 2'b01,1,8'hA0,0,1,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b00,8'hA2,8'h00,1, 2'b01,1,8'hA1,0,1,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b01,8'hA3,8'h00,1, 2'b01,1,8'hA2,0,1,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,1,8'hA3,1,0,0));
        // sel gating; non-head master valid ignored
        vecs.push_back(mk(1,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,2'b11,2'b10,2'b11,8'h55,8'h66,1, 2'b00,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b11,2'b10,2'b11,8'h55,8'h66,1, 2'b00,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b01,8'h55,8'h00,1, 2'b01,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,1,8'h55,1,0,0));
        // slave backpressure on a 3-beat burst from m1
        vecs.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00,0, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b00,8'h00,8'hB0,0, 2'b10,0,8'h00,0,1,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b00,8'h00,8'hB1,0, 2'b10,1,8'hB0,0,1,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hB2,0, 2'b00,1,8'hB0,0,1,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hB2,0, 2'b00,1,8'hB0,0,1,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hB2,1, 2'b00,1,8'hB0,0,1,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hB2,1, 2'b10,1,8'hB1,0,1,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,1,8'hB2,1,0,0));
        // fill FIFO with 0,1,0,1 then push 1 while popping the head
        vecs.push_back(mk(1,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,0,0));
        vecs.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,2,0));
        vecs.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,3,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,4,1));
        vecs.push_back(mk(1,1,2'b01,2'b01,2'b01,8'hC0,8'h00,1, 2'b01,0,8'h00,0,4,1));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hD1,1, 2'b10,1,8'hC0,1,4,1));
        vecs.push_back(mk(0,0,2'b01,2'b01,2'b01,8'hD2,8'h00,1, 2'b01,1,8'hD1,1,3,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hD3,1, 2'b10,1,8'hD2,1,2,0));
        vecs.push_back(mk(0,0,2'b10,2'b10,2'b10,8'h00,8'hD4,1, 2'b10,1,8'hD3,1,1,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,1,8'hD4,1,0,0));
        vecs.push_back(mk(0,0,2'b00,2'b00,2'b00,8'h00,8'h00,1, 2'b00,0,8'h00,0,0,0));

        // reset state, with valid/sel asserted so WREADY gating is exercised
        rst_n = 1'b0;
        drive(0, 0, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00, 1);
        #1;
        check("rst s_WVALID",  32'(bus.s_WVALID_o),    0);
        check("rst s_WDATA",   bus.s_WDATA_o,          0);
        check("rst s_WLAST",   32'(bus.s_WLAST_o),     0);
        check("rst pending",   32'(bus.pending_o),     0);
        check("rst stall",     32'(bus.sa_AW_stall_o), 0);
        check("rst WREADY",    32'(bus.dsp_WREADY_o),  0);
        repeat (2) @(negedge clk);
        drive(0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].push, vecs[i].id, vecs[i].wv, vecs[i].sel, vecs[i].wl,
                  vecs[i].d0, vecs[i].d1, vecs[i].rdy);
            #1;
            check($sformatf("v%0d WREADY", i),  32'(bus.dsp_WREADY_o),  32'(vecs[i].e_wready));
            check($sformatf("v%0d s_WVALID", i), 32'(bus.s_WVALID_o),   32'(vecs[i].e_sv));
            if (vecs[i].e_sv) begin
                check($sformatf("v%0d s_WDATA", i), bus.s_WDATA_o,       32'(vecs[i].e_sd));
                check($sformatf("v%0d s_WLAST", i), 32'(bus.s_WLAST_o),  32'(vecs[i].e_sl));
            end
            check($sformatf("v%0d pending", i), 32'(bus.pending_o),     32'(vecs[i].e_pend));
            check($sformatf("v%0d stall", i),   32'(bus.sa_AW_stall_o), 32'(vecs[i].e_stall));
        end

        // reset mid-burst: 2 FIFO entries, one beat parked in the output stage
        @(negedge clk); drive(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
        @(negedge clk); drive(1, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0);
        @(negedge clk); drive(0, 0, 2'b01, 2'b01, 2'b00, 8'hE0, 8'h00, 0);
        @(negedge clk);
        #1;
        check("pre-rst s_WVALID", 32'(bus.s_WVALID_o),   1);
        check("pre-rst s_WDATA",  bus.s_WDATA_o,         32'hE0);
        check("pre-rst pending",  32'(bus.pending_o),    2);
        check("pre-rst WREADY",   32'(bus.dsp_WREADY_o), 1);
        rst_n = 1'b0;
        #1;
        check("mid-rst s_WVALID", 32'(bus.s_WVALID_o),    0);
        check("mid-rst pending",  32'(bus.pending_o),     0);
        check("mid-rst stall",    32'(bus.sa_AW_stall_o), 0);
        check("mid-rst WREADY",   32'(bus.dsp_WREADY_o),  0);
        @(posedge clk);
        #1;
        check("mid-rst+1 s_WVALID", 32'(bus.s_WVALID_o),   0);
        check("mid-rst+1 s_WDATA",  bus.s_WDATA_o,         0);
        check("mid-rst+1 WREADY",   32'(bus.dsp_WREADY_o), 0);
        @(negedge clk);
        drive(0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post-rst pending", 32'(bus.pending_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
